// File: rtl/raycast_pkg.sv
// Shared screen geometry, pose/height widths and scheduler state encoding
// for the raycast column pipeline.
package raycast_pkg;

  localparam int SCREEN_COLS = 160;
  localparam int SCREEN_ROWS = 120;

  localparam int POS_W    = 13;
  localparam int ANG_W    = 10;
  localparam int HEIGHT_W = 7;
  localparam int COL_W    = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_ARM   = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_STORE = 3'd5,
    S_SWAP  = 3'd6
  } sched_state_e;

  // Engine heights can exceed the visible rows; saturate to the screen height.
  function automatic logic [HEIGHT_W-1:0] clamp_height(input logic [HEIGHT_W-1:0] h,
                                                       input int max_h);
    if (32'(h) > max_h) return HEIGHT_W'(max_h);
    return h;
  endfunction

endpackage

// File: rtl/slice_column_scheduler_if.sv
// Handshake bundle between the column scheduler and the slice-height engine.
interface slice_column_scheduler_if
  import raycast_pkg::*;
();

  logic signed [POS_W-1:0]    playerX;
  logic signed [POS_W-1:0]    playerY;
  logic        [ANG_W-1:0]    angle_X;
  logic        [ANG_W-1:0]    angle_Y;
  logic        [COL_W-1:0]    column_count;
  logic                       begin_calc;
  logic                       end_calc;
  logic        [HEIGHT_W-1:0] slice_size;

  modport master (
    output playerX, playerY, angle_X, angle_Y, column_count, begin_calc,
    input  end_calc, slice_size
  );

  modport slave (
    input  playerX, playerY, angle_X, angle_Y, column_count, begin_calc,
    output end_calc, slice_size
  );

endinterface

// File: rtl/column_height_buffer.sv
// Double-buffered column-height store: writes go to the back bank, the
// registered read port serves the front bank and zeroes out-of-range columns.
module column_height_buffer #(
  parameter int NUM_COLS = 160,
  parameter int AW       = 8,
  parameter int DW       = 7
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          swap_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [2][NUM_COLS];
  logic          front_sel_q;
  logic [DW-1:0] rd_data_q;

  // Storage is deliberately unreset so a mid-frame reset keeps the last image.
  always_ff @(posedge clock) begin
    if (wr_en_i && (32'(wr_addr_i) < NUM_COLS))
      mem_q[~front_sel_q][wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      front_sel_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      if (swap_i) front_sel_q <= ~front_sel_q;
      rd_data_q <= (32'(rd_addr_i) < NUM_COLS) ? mem_q[front_sel_q][rd_addr_i] : '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/slice_column_scheduler.sv
// Walks the slice engine across every screen column of a frame, clamps each
// height into the back buffer and swaps buffers when the frame is complete.
module slice_column_scheduler
  import raycast_pkg::*;
#(
  parameter int NUM_COLS   = SCREEN_COLS,
  parameter int MAX_HEIGHT = SCREEN_ROWS,
  parameter int TIMEOUT    = 1023,
  parameter int TO_W       = 10
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       frame_start,
  input  logic signed [POS_W-1:0]    pose_playerX,
  input  logic signed [POS_W-1:0]    pose_playerY,
  input  logic        [ANG_W-1:0]    pose_angle_X,
  input  logic        [ANG_W-1:0]    pose_angle_Y,
  slice_column_scheduler_if.master   eng,
  input  logic        [COL_W-1:0]    rd_col,
  output logic        [HEIGHT_W-1:0] rd_height,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       timeout_evt,
  output logic                       overrun
);

  sched_state_e               state_q;
  logic        [COL_W-1:0]    col_q;
  logic        [TO_W-1:0]     to_cnt_q;
  logic        [HEIGHT_W-1:0] h_q, h_d;
  logic                       begin_q, busy_q, done_q, to_evt_q, overrun_q;
  logic signed [POS_W-1:0]    px_q, py_q;
  logic        [ANG_W-1:0]    ax_q, ay_q;

  assign h_d = clamp_height(eng.slice_size, MAX_HEIGHT);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      to_cnt_q  <= '0;
      h_q       <= '0;
      begin_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      to_evt_q  <= 1'b0;
      overrun_q <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
      ax_q      <= '0;
      ay_q      <= '0;
    end else begin
      begin_q  <= 1'b0;
      done_q   <= 1'b0;
      to_evt_q <= 1'b0;
      if (frame_start && (state_q != S_IDLE)) overrun_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          col_q <= '0;
          if (frame_start) begin
            overrun_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_LATCH;
          end
        end
        S_LATCH: begin
          px_q    <= pose_playerX;
          py_q    <= pose_playerY;
          ax_q    <= pose_angle_X;
          ay_q    <= pose_angle_Y;
          state_q <= S_ARM;
        end
        // Hold off until the engine drops the previous column's done level.
        S_ARM: begin
          if (!eng.end_calc) begin
            begin_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          to_cnt_q <= '0;
          state_q  <= S_WAIT;
        end
        // A result arriving on the timeout cycle still takes priority.
        S_WAIT: begin
          if (eng.end_calc) begin
            h_q     <= h_d;
            state_q <= S_STORE;
          end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            h_q      <= '0;
            to_evt_q <= 1'b1;
            state_q  <= S_STORE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        S_STORE: begin
          if (col_q == COL_W'(NUM_COLS - 1)) begin
            state_q <= S_SWAP;
          end else begin
            col_q   <= col_q + 1'b1;
            state_q <= S_ARM;
          end
        end
        S_SWAP: begin
          col_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  column_height_buffer #(
    .NUM_COLS (NUM_COLS),
    .AW       (COL_W),
    .DW       (HEIGHT_W)
  ) u_buf (
    .clock     (clock),
    .resetn    (resetn),
    .swap_i    (state_q == S_SWAP),
    .wr_en_i   (state_q == S_STORE),
    .wr_addr_i (col_q),
    .wr_data_i (h_q),
    .rd_addr_i (rd_col),
    .rd_data_o (rd_height)
  );

  assign eng.playerX      = px_q;
  assign eng.playerY      = py_q;
  assign eng.angle_X      = ax_q;
  assign eng.angle_Y      = ay_q;
  assign eng.column_count = col_q;
  assign eng.begin_calc   = begin_q;

  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign timeout_evt = to_evt_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_slice_column_scheduler.sv
// Frame-level bench: stub slice engine, column-order scoreboard and a
// two-bank height model checked through the drawer read port.
module tb_slice_column_scheduler;
  import raycast_pkg::*;

  logic                       clock = 1'b0;
  logic                       resetn = 1'b0;
  logic                       frame_start = 1'b0;
  logic signed [POS_W-1:0]    pose_playerX = '0, pose_playerY = '0;
  logic        [ANG_W-1:0]    pose_angle_X = '0, pose_angle_Y = '0;
  logic        [COL_W-1:0]    rd_col = '0;
  logic        [HEIGHT_W-1:0] rd_height;
  logic                       busy, frame_done, timeout_evt, overrun;

  slice_column_scheduler_if eng_if ();

  slice_column_scheduler #(
    .NUM_COLS   (160),
    .MAX_HEIGHT (120),
    .TIMEOUT    (20),
    .TO_W       (10)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .frame_start  (frame_start),
    .pose_playerX (pose_playerX),
    .pose_playerY (pose_playerY),
    .pose_angle_X (pose_angle_X),
    .pose_angle_Y (pose_angle_Y),
    .eng          (eng_if),
    .rd_col       (rd_col),
    .rd_height    (rd_height),
    .busy         (busy),
    .frame_done   (frame_done),
    .timeout_evt  (timeout_evt),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0;
  int fd_cnt = 0, to_cnt = 0;
  int colq[$];
  int rdq[$];

  // stub engine configuration
  int off = 0, big_col = -1, stall_col = -1, hold = 0;

  logic [HEIGHT_W-1:0] bank [2][160];
  bit msel = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int stub_val(input int c);
    return (c == big_col) ? 127 : (c + off) % 100;
  endfunction

  function automatic int exp_h(input int c);
    int v;
    if (c == stall_col) return 0;
    v = stub_val(c);
    return (v > 120) ? 120 : v;
  endfunction

  // Stub slice engine: answers 5 cycles after begin_calc, holds done 1+hold cycles.
  initial begin
    int sc;
    eng_if.end_calc   = 1'b0;
    eng_if.slice_size = '0;
    forever begin
      @(posedge clock); #1;
      if (resetn && eng_if.begin_calc) begin
        sc = int'(eng_if.column_count);
        if (sc != stall_col) begin
          repeat (5) @(posedge clock);
          #1;
          eng_if.slice_size = 7'(stub_val(sc));
          eng_if.end_calc   = 1'b1;
          repeat (1 + hold) @(posedge clock);
          #1;
          eng_if.end_calc = 1'b0;
        end
      end
    end
  end

  // Scoreboard: each begin_calc must present the next queued column.
  always @(negedge clock) begin
    if (resetn) begin
      if (eng_if.begin_calc) begin
        chk("end_calc_low_at_begin", {31'd0, eng_if.end_calc}, 32'd0);
        chk("column_count", {24'd0, eng_if.column_count},
            (colq.size() != 0) ? colq.pop_front() : 32'hFFFF_FFFF);
      end
      if (frame_done)  fd_cnt++;
      if (timeout_evt) to_cnt++;
    end
  end

  task automatic rd_chk(input int c);
    int e;
    e = (c < 160) ? int'(bank[msel][c]) : 0;
    @(negedge clock);
    rd_col = c[7:0];
    rdq.push_back(e);
    @(negedge clock);
    chk($sformatf("rd_height[%0d]", c), {25'd0, rd_height}, rdq.pop_front());
  endtask

  task automatic run_frame(input int f_off, input int f_big, input int f_stall,
                           input int f_hold, input bit f_ovr, input int f_rst);
    int fd0, to0, ovr_ph;
    logic signed [POS_W-1:0] px, py;
    logic        [ANG_W-1:0] ax, ay;
    off = f_off; big_col = f_big; stall_col = f_stall; hold = f_hold;
    colq.delete();
    for (int c = 0; c < 160; c++) colq.push_back(c);
    fd0 = fd_cnt; to0 = to_cnt; ovr_ph = 0;
    px = 13'($urandom); py = 13'($urandom);
    ax = 10'($urandom); ay = 10'($urandom);

    @(negedge clock);
    pose_playerX = px; pose_playerY = py; pose_angle_X = ax; pose_angle_Y = ay;
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("overrun_cleared", {31'd0, overrun}, 32'd0);

    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clock);
      if (cyc == 30) begin
        pose_playerX = ~px; pose_playerY = ~py; pose_angle_X = ~ax; pose_angle_Y = ~ay;
      end
      if (ovr_ph == 1) begin
        frame_start = 1'b0;
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        ovr_ph = 2;
      end else if (f_ovr && ovr_ph == 0 && eng_if.column_count == 8'd50) begin
        frame_start = 1'b1;
        ovr_ph = 1;
      end
      if (f_rst >= 0 && int'(eng_if.column_count) == f_rst) break;
      if (fd_cnt != fd0) break;
    end

    if (f_rst >= 0) begin
      chk("reached_reset_col", {24'd0, eng_if.column_count}, f_rst);
      #2 resetn = 1'b0;
      #1;
      chk("rst_column_count", {24'd0, eng_if.column_count}, 32'd0);
      chk("rst_begin_calc", {31'd0, eng_if.begin_calc}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
      chk("rst_rd_height", {25'd0, rd_height}, 32'd0);
      chk("rst_playerX", eng_if.playerX, 32'd0);
      chk("rst_angle_X", {22'd0, eng_if.angle_X}, 32'd0);
      repeat (3) @(negedge clock);
      resetn = 1'b1;
      colq.delete();
      repeat (300) @(negedge clock);
      chk("no_frame_done_after_reset", fd_cnt, fd0);
      msel = 1'b0;
    end else begin
      chk("frame_done_count", fd_cnt - fd0, 32'd1);
      chk("columns_left", colq.size(), 32'd0);
      chk("timeout_evts", to_cnt - to0, (f_stall >= 0) ? 32'd1 : 32'd0);
      chk("busy_after_frame", {31'd0, busy}, 32'd0);
      chk("playerX_held", eng_if.playerX, px);
      chk("playerY_held", eng_if.playerY, py);
      chk("angle_X_held", {22'd0, eng_if.angle_X}, {22'd0, ax});
      chk("angle_Y_held", {22'd0, eng_if.angle_Y}, {22'd0, ay});
      for (int c = 0; c < 160; c++) bank[!msel][c] = 7'(exp_h(c));
      msel = !msel;
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_begin_calc", {31'd0, eng_if.begin_calc}, 32'd0);
    chk("reset_column_count", {24'd0, eng_if.column_count}, 32'd0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);
    chk("reset_rd_height", {25'd0, rd_height}, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // frame 1: col%100, column 10 over-range for the clamp
    run_frame(0, 10, -1, 0, 1'b0, -1);
    rd_chk(37); rd_chk(10); rd_chk(11); rd_chk(159); rd_chk(200);

    // frame 2: stalled column 5, sticky done, overrun request at column 50
    run_frame(3, -1, 5, 3, 1'b1, -1);
    rd_chk(5); rd_chk(4); rd_chk(50); rd_chk(10);

    // frame 3: reset at column 80, previous image must survive
    run_frame(7, -1, -1, 0, 1'b0, 80);
    rd_chk(5); rd_chk(100); rd_chk(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
